// File: rtl/jk_pkg.sv
// Shared JK drive encodings and helpers for counters built from JK flip-flop cells.
// A drive is the {j,k} pair presented to one cell for the coming clock edge.
package jk_pkg;

  typedef struct packed {
    logic j;
    logic k;
  } jk_drive_t;

  localparam jk_drive_t JK_HOLD = '{j: 1'b0, k: 1'b0};
  localparam jk_drive_t JK_SET  = '{j: 1'b1, k: 1'b0};
  localparam jk_drive_t JK_CLR  = '{j: 1'b0, k: 1'b1};
  localparam jk_drive_t JK_TOG  = '{j: 1'b1, k: 1'b1};

  // Minimal-activity drive: leave a bit alone when it already matches, toggle it otherwise.
  function automatic jk_drive_t jk_for_target(input logic q, input logic d);
    return (q == d) ? JK_HOLD : JK_TOG;
  endfunction

endpackage

// File: rtl/jkff_sr.sv
// JK flip-flop cell with synchronous active-high reset; reset wins over any J/K drive.
module jkff_sr (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_modn_counter.sv
// Modulo-N up/down counter whose state lives entirely in JK cells; this level only
// works out the per-bit J/K drive plus the registered wrap and load-error pulses.
module jk_modn_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_badModulus
    $error("jk_modn_counter: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_stepTarget;
  logic [WIDTH-1:0] w_loadTarget;
  logic             w_atLast;
  logic             w_atZero;
  logic             w_countInRange;
  logic             w_loadInRange;
  logic             w_tc;
  logic             r_wrap;
  logic             r_loadErr;
  jk_drive_t        w_drive [WIDTH];

  assign w_atLast       = (count == LAST);
  assign w_atZero       = &w_qbar;
  assign w_countInRange = (int'(count) < MODULUS);
  assign w_loadInRange  = (int'(load_val) < MODULUS);
  assign w_loadTarget   = w_loadInRange ? load_val : LAST;

  // An out-of-range count falls back to the wrap destination of the current direction.
  always_comb begin
    w_stepTarget = '0;
    if (up) begin
      w_stepTarget = (w_atLast || !w_countInRange) ? '0 : count + WIDTH'(1);
    end else begin
      w_stepTarget = (w_atZero || !w_countInRange) ? LAST : count - WIDTH'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_drive[i] = JK_HOLD;
      if (rst) begin
        w_drive[i] = JK_HOLD;
      end else if (load) begin
        w_drive[i] = w_loadTarget[i] ? JK_SET : JK_CLR;
      end else if (en) begin
        w_drive[i] = jk_for_target(count[i], w_stepTarget[i]);
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jkff_sr u_cell (
      .clk  (clk),
      .rst  (rst),
      .j    (w_drive[i].j),
      .k    (w_drive[i].k),
      .q    (count[i]),
      .qbar (w_qbar[i])
    );
  end

  assign w_tc = en & ~rst & ~load & ((up & w_atLast) | (~up & w_atZero));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap    <= 1'b0;
      r_loadErr <= 1'b0;
    end else begin
      r_wrap    <= w_tc;
      r_loadErr <= load & ~w_loadInRange;
    end
  end

  assign tc       = w_tc;
  assign wrap     = r_wrap;
  assign load_err = r_loadErr;

endmodule

// File: tb/tb_jk_modn_counter.sv
// Scoreboard bench: a decimal counter and a power-of-two counter share one stimulus
// stream and are compared every cycle against a modular-arithmetic reference model.
module tb_jk_modn_counter;

  localparam int W1 = 4;
  localparam int M1 = 10;
  localparam int W2 = 3;
  localparam int M2 = 8;

  typedef struct {
    int c;
    bit tc;
    bit w;
    bit e;
  } expT;

  typedef struct {
    expT a;
    expT b;
  } pairT;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic up;
  logic load;
  logic [W1-1:0] loadVal;
  logic [W1-1:0] count1;
  logic [W2-1:0] count2;
  logic tc1, wrap1, err1;
  logic tc2, wrap2, err2;

  pairT sbQ[$];
  int   mc1 = 0;
  int   mc2 = 0;
  int   nChecks = 0;
  int   nErrors = 0;

  always #5 clk = ~clk;

  jk_modn_counter #(.WIDTH(W1), .MODULUS(M1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(loadVal),
    .count(count1), .tc(tc1), .wrap(wrap1), .load_err(err1)
  );

  jk_modn_counter #(.WIDTH(W2), .MODULUS(M2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(loadVal[W2-1:0]),
    .count(count2), .tc(tc2), .wrap(wrap2), .load_err(err2)
  );

  // Next observable state after one edge; tc is evaluated with the inputs still applied.
  function automatic expT stepModel(input int mod, input int c, input bit r, input bit l,
                                    input bit e, input bit u, input int lv);
    expT res;
    res.c = c; res.w = 0; res.e = 0;
    if (r) begin
      res.c = 0;
    end else if (l) begin
      if (lv < mod) res.c = lv;
      else begin
        res.c = mod - 1;
        res.e = 1;
      end
    end else if (e) begin
      res.w = (u && c == mod - 1) || (!u && c == 0);
      res.c = u ? (c + 1) % mod : (c + mod - 1) % mod;
    end
    res.tc = e && !r && !l && ((u && res.c == mod - 1) || (!u && res.c == 0));
    return res;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit l, input bit e, input bit u, input int lv);
    pairT p;
    @(negedge clk);
    rst = r; load = l; en = e; up = u; loadVal = W1'(lv);
    p.a = stepModel(M1, mc1, r, l, e, u, lv);
    p.b = stepModel(M2, mc2, r, l, e, u, lv & 7);
    mc1 = p.a.c;
    mc2 = p.b.c;
    sbQ.push_back(p);
  endtask

  initial begin : monitor
    pairT p;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        p = sbQ.pop_front();
        checkOutput("count_m10", int'(count1), p.a.c);
        checkOutput("tc_m10", int'(tc1), int'(p.a.tc));
        checkOutput("wrap_m10", int'(wrap1), int'(p.a.w));
        checkOutput("loadErr_m10", int'(err1), int'(p.a.e));
        checkOutput("count_m8", int'(count2), p.b.c);
        checkOutput("tc_m8", int'(tc2), int'(p.b.tc));
        checkOutput("wrap_m8", int'(wrap2), int'(p.b.w));
        checkOutput("loadErr_m8", int'(err2), int'(p.b.e));
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b0; loadVal = '0;
    repeat (2) applyStimulus(1, 0, 0, 0, 0);
    repeat (12) applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 2);
    repeat (4) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 9);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 12);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 5);
    applyStimulus(0, 1, 0, 0, 4);
    repeat (5) applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, (i % 2) == 0, 0);
    applyStimulus(0, 1, 0, 0, 9);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(1, 1, 0, 0, 7);
    repeat (9) applyStimulus(0, 0, 1, 1, 0);
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 15)));
    end
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/jk_modn_counter.md
Name: jk_modn_counter

Overview:
- Synchronous modulo-N up/down counter assembled from JK flip-flop cells; the next stage downstream of the team's JK flip-flop primitive.
- Every state bit is held in a JK cell. The block's own logic only derives the per-bit J/K drive from the current count, direction, load and enable.
- Consumers are the Day-series timer/sequence blocks. They use `count`, the combinational terminal-count flag `tc` and the registered `wrap` pulse.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1.
  - Legal range is 2 <= MODULUS <= 2**WIDTH.
  - An illegal value is an elaboration-time error via $error in an initial/generate check.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count, direct Q outputs of the JK cells.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap occurred.
- load_err  output  1  registered one-cycle pulse, high in the cycle after an out-of-range load.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high. No asynchronous reset anywhere in the block.
- Reset values: count = 0, wrap = 0, load_err = 0. tc then follows its equation from the reset state.
- Priority at each rising edge: rst, then load, then en, then hold.
- rst = 1:
  - All JK cells clear to 0. Clearing is by the cell's sync reset, not by J/K drive.
  - wrap and load_err clear.
  - load and en are ignored.
- load = 1 (rst = 0):
  - If load_val < MODULUS: count <= load_val.
  - Else: count <= MODULUS-1 and load_err = 1 next cycle.
  - Per bit the drive is J = target bit, K = ~target bit.
  - A load never asserts wrap, even if en is also high.
- en = 1 (rst = 0, load = 0):
  - Up: count <= (count == MODULUS-1) ? 0 : count+1.
  - Down: count <= (count == 0) ? MODULUS-1 : count-1.
  - Bits that change get J = K = 1 (toggle); all other bits get J = K = 0.
  - Wrap-around assertion: if count is forced out of range (only possible via formal/X injection), the next enabled step goes to 0 (up) or MODULUS-1 (down).
- en = 0 (no load, no reset): J = K = 0 on every cell; count holds.
- tc = en & ((up & count == MODULUS-1) | (~up & count == 0)).
  - Purely combinational, same cycle as the count value.
  - tc is forced 0 while rst or load is high.
- wrap: registered copy of tc, so it is high for exactly the one cycle after the edge on which the wrap occurred.
- Latency: count updates one clock after the sampled control. tc has zero latency; wrap and load_err have one-cycle latency.
- Direction change: `up` may change on any cycle and takes effect on the next enabled edge. There is no pipeline to flush.
- Reset mid-operation: reset takes effect on the next edge regardless of load/en. wrap or load_err pending in the same edge is dropped (both read 0 after reset).
- Power-of-two case (MODULUS == 2**WIDTH): behaves as a natural binary wrap; tc and wrap logic are unchanged.

Decomposition:
- Package `jk_pkg` holds:
  - typedef `jk_drive_t`: struct {logic j; logic k;}.
  - Constants JK_HOLD = '{0,0}, JK_SET = '{1,0}, JK_CLR = '{0,1}, JK_TOG = '{1,1}.
  - Function `jk_for_target(q, d)` returning the drive that moves q to d.
- Sub-module `jkff_sr`: JK flip-flop with synchronous active-high reset.
  - Ports: clk, rst, j, k, q, qbar.
  - One instance per bit via a generate loop; all count state lives in these instances.
- wrap and load_err are plain registers in the top level.

Test Plan:
- Reset then up-count (WIDTH = 4, MODULUS = 10): rst high 2 cycles, then en = 1, up = 1 for 12 cycles.
  - count goes 0, 1, …, 9, 0, 1.
  - tc is high only while count = 9.
  - wrap is high only in the cycle count = 0 first appears after 9.
- Down-count wrap: load 2, then en = 1, up = 0 for 4 cycles.
  - count goes 2, 1, 0, 9, 8.
  - tc is high while count = 0.
  - wrap pulses once, coincident with count = 9.
- Load boundary:
  - load_val = 9: count = 9, load_err = 0.
  - load_val = 12: count = 9, load_err = 1 for exactly one cycle.
  - load with en = 1 at count = 9, up = 1: count = load_val and no wrap.
- Hold and direction flip:
  - en = 0 for 5 cycles at count = 4: count stays 4, tc = 0.
  - Then en = 1 with up toggling every cycle from 4: count goes 5, 4, 5, 4.
- Reset mid-operation:
  - rst asserted on the same edge as a wrap (count = 9, up, en): next cycle count = 0, wrap = 0, load_err = 0.
  - rst with load = 1, load_val = 7: count = 0.
- Power-of-two (WIDTH = 3, MODULUS = 8):
  - Up-count from 0 for 9 cycles: count goes 0…7, 0, with wrap pulsing once.
  - Elaboration with MODULUS = 9, WIDTH = 3 must fail.
